regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports with write-through forwarding and two write ports, where port 1 has priority.
// Define REGFILE_SCOREBOARD_EN to add the busy-bit scoreboard and alloc port. Without it, rd_busy is tied to 0.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs    [DEPTH];
    logic [ADDR_W-1:0] rd_a    [NRD];
    logic [DATA_W-1:0] rd_next [NRD];
    logic              w0_ok;
    logic              w1_ok;

    // Writes to r0 are squashed here, so r0 never leaves its reset value of 0 and needs no read-side special case.
    assign w0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign w1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (w0_ok) regs[wr0_addr] <= wr0_data;
            if (w1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
            if (w1_ok && (wr1_addr == rd_a[i])) begin
                rd_next[i] = wr1_data;
            end else if (w0_ok && (wr0_addr == rd_a[i])) begin
                rd_next[i] = wr0_data;
            end else begin
                rd_next[i] = regs[rd_a[i]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int unsigned i = 0; i < NRD; i++) begin
                if (rd_en[i]) rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    // Alloc is applied after the write clears, so a new producer issued on the same edge keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (w0_ok) busy_next[wr0_addr] = 1'b0;
        if (w1_ok) busy_next[wr1_addr] = 1'b0;
        if (alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0)))
            busy_next[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            rd_busy <= '0;
        end else begin
            busy <= busy_next;
            for (int unsigned i = 0; i < NRD; i++) begin
                if (rd_en[i]) rd_busy[i] <= busy_next[rd_a[i]];
            end
        end
    end
`else
    logic unused_alloc;
    assign unused_alloc = ^{alloc_en, alloc_addr};
    assign rd_busy      = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic checked against a behavioural array model.
// When REGFILE_SCOREBOARD_EN is defined, the model also tracks the scoreboard. Otherwise it expects rd_busy to stay 0.
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int ZR    = 1;
    localparam int DEPTH = 2 ** AW;
`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr0_en, wr1_en, alloc_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, alloc_addr;
    logic [DW-1:0]     wr0_data, wr1_data;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(ZR)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural register contents, busy bits, and the last value each port returned.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    logic [DW-1:0] m_data [NR];
    bit            m_rbsy [NR];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            chk_on = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            m_data[i] = '0;
            m_rbsy[i] = 1'b0;
        end
    endtask

    function automatic bit writable(input logic [AW-1:0] a);
        return !(ZR != 0 && a == '0);
    endfunction

    // Architectural effect of one clock edge: apply writes (port 1 last, so it wins), then busy updates, then reads see the result.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (wr0_en && writable(wr0_addr)) begin
            m_mem[wr0_addr] = wr0_data;
            m_busy[wr0_addr] = 1'b0;
        end
        if (wr1_en && writable(wr1_addr)) begin
            m_mem[wr1_addr] = wr1_data;
            m_busy[wr1_addr] = 1'b0;
        end
        if (alloc_en && writable(alloc_addr)) m_busy[alloc_addr] = 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (rd_en[i]) begin
                m_data[i] = m_mem[rd_addr[i*AW +: AW]];
                m_rbsy[i] = SB && m_busy[rd_addr[i*AW +: AW]];
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NR; i++) begin
                check($sformatf("model rd_data[%0d]", i), rd_data[i*DW +: DW], m_data[i]);
                check($sformatf("model rd_busy[%0d]", i), {31'd0, rd_busy[i]}, {31'd0, m_rbsy[i]});
            end
        end
    end

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        idle();
    endtask

    task automatic lit(input string name, input int p, input logic [DW-1:0] d, input bit b);
        check({name, " data"}, rd_data[p*DW +: DW], d);
        check({name, " busy"}, {31'd0, rd_busy[p]}, {31'd0, b});
        check({name, " model"}, m_data[p], d);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) cyc();
        chk_on = 1'b1;
        lit("reset p0", 0, 32'h0, 1'b0);
        lit("reset p1", 1, 32'h0, 1'b0);
        rst_n = 1'b1;

        // Forwarding: write and read on the same edge.
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h11; rd(0, 5'd3); rd(1, 5'd3);
        cyc();
        lit("fwd p0", 0, 32'h11, 1'b0);
        lit("fwd p1", 1, 32'h11, 1'b0);
        rd(1, 5'd3); cyc();
        lit("fwd later", 1, 32'h11, 1'b0);

        // Write collision on r7.
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAA;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h5555; rd(0, 5'd7);
        cyc();
        lit("collide", 0, 32'h5555, 1'b0);
        rd(1, 5'd7); cyc();
        lit("collide later", 1, 32'h5555, 1'b0);

        // Zero register.
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0; rd(0, 5'd0);
        cyc();
        lit("zero same", 0, 32'h0, 1'b0);
        rd(0, 5'd0); cyc();
        lit("zero later", 0, 32'h0, 1'b0);

        // Scoreboard sequence on r9.
        alloc_en = 1'b1; alloc_addr = 5'd9; cyc();
        rd(0, 5'd9); cyc();
        lit("sb alloc", 0, 32'h0, SB);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h42;
        alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 5'd9);
        cyc();
        lit("sb realloc", 0, 32'h42, SB);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h43; rd(1, 5'd9);
        cyc();
        lit("sb clear", 1, 32'h43, 1'b0);

        // Read hold.
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h77; rd(0, 5'd2); cyc();
        lit("hold first", 0, 32'h77, 1'b0);
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h88; rd_addr[0 +: AW] = 5'd2; cyc();
        lit("hold kept", 0, 32'h77, 1'b0);
        rd_addr[0 +: AW] = 5'd2; cyc();
        lit("hold kept2", 0, 32'h77, 1'b0);
        rd(0, 5'd2); cyc();
        lit("hold release", 0, 32'h88, 1'b0);

        // Mid-stream asynchronous reset.
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; rd(0, 5'd5);
        alloc_en = 1'b1; alloc_addr = 5'd6; rd(1, 5'd6);
        cyc();
        lit("pre-reset", 0, 32'hDEADBEEF, 1'b0);
        lit("pre-reset busy", 1, 32'h0, SB);
        #1 rst_n = 1'b0; model_reset();
        #1;
        lit("async reset p0", 0, 32'h0, 1'b0);
        lit("async reset p1", 1, 32'h0, 1'b0);
        cyc();
        rst_n = 1'b1;
        rd(0, 5'd5); rd(1, 5'd6); cyc();
        lit("post-reset r5", 0, 32'h0, 1'b0);
        lit("post-reset r6", 1, 32'h0, 1'b0);

        // Randomized traffic on a narrow address range, to provoke collisions and forwarding.
        for (int n = 0; n < 600; n++) begin
            rd_en = NR'($urandom);
            for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            wr0_en = ($urandom_range(0, 3) != 0); wr0_addr = AW'($urandom_range(0, 7)); wr0_data = $urandom;
            wr1_en = ($urandom_range(0, 2) == 0); wr1_addr = AW'($urandom_range(0, 7)); wr1_data = $urandom;
            alloc_en = ($urandom_range(0, 1) == 0); alloc_addr = AW'($urandom_range(0, 7));
            if (n % 97 == 50) begin
                rst_n = 1'b0; model_reset();
            end else begin
                rst_n = 1'b1;
            end
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        chk_on = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
